// File: rtl/bus_cycle_controller.sv
// Bus cycle terminator for the 68000 on Mackerel-10: per-region wait states, expansion
// handshake, IACK autovectoring, bus-error watchdog and the reset-vector BOOT overlay.
module bus_cycle_controller #(
    parameter int ROM_WAIT     = 2,
    parameter int RAM_WAIT     = 0,
    parameter int IO_WAIT      = 4,
    parameter int BERR_TIMEOUT = 64,
    parameter int BOOT_CYCLES  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       RW,
    input  logic [2:0] FC,
    input  logic       ROM_SEL,
    input  logic       RAM_SEL,
    input  logic       IO_SEL,
    input  logic       EXP_SEL,
    input  logic       EXP_DTACK,
    output logic       DTACK,
    output logic       VPA,
    output logic       BERR,
    output logic       BOOT,
    output logic       CYCLE_END
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_EXT   = 3'd2;
    localparam logic [2:0] S_NOSEL = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam logic [7:0] ROM_N     = 8'(ROM_WAIT);
    localparam logic [7:0] RAM_N     = 8'(RAM_WAIT);
    localparam logic [7:0] IO_N      = 8'(IO_WAIT);
    localparam logic [7:0] TMO_LAST  = 8'(BERR_TIMEOUT - 1);
    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic       iack_q, iack_d;
    logic       boot_q, boot_d;
    logic       dtack_q, dtack_d;
    logic       vpa_q, vpa_d;
    logic       berr_q, berr_d;
    logic       cend_q, cend_d;
    logic       exp_s1_q, exp_s1_d;
    logic       exp_s2_q, exp_s2_d;

    // RW carries no information this block needs; kept on the port for board compatibility.
    logic rw_unused;
    assign rw_unused = RW;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        iack_d   = iack_q;
        boot_d   = boot_q;
        dtack_d  = dtack_q;
        vpa_d    = vpa_q;
        berr_d   = berr_q;
        cend_d   = 1'b0;
        exp_s1_d = EXP_DTACK;
        exp_s2_d = exp_s1_q;
        case (state_q)
            S_IDLE: begin
                if (!AS) begin
                    tcnt_d = 8'd0;
                    wcnt_d = 8'd0;
                    iack_d = 1'b0;
                    // IACK reuses WAIT with no delay so VPA lands one edge after decode.
                    if (FC == 3'b111) begin
                        state_d = S_WAIT;
                        iack_d  = 1'b1;
                    end else if (ROM_SEL) begin
                        state_d = S_WAIT;
                        wcnt_d  = ROM_N;
                    end else if (RAM_SEL) begin
                        state_d = S_WAIT;
                        wcnt_d  = RAM_N;
                    end else if (IO_SEL) begin
                        state_d = S_WAIT;
                        wcnt_d  = IO_N;
                    end else if (EXP_SEL) begin
                        state_d = S_EXT;
                    end else begin
                        state_d = S_NOSEL;
                    end
                end
            end
            S_WAIT, S_EXT, S_NOSEL: begin
                if (AS) begin
                    state_d = S_IDLE;
                end else if (state_q == S_WAIT && wcnt_q == 8'd0) begin
                    state_d = S_ACK;
                    if (iack_q) vpa_d = 1'b0;
                    else        dtack_d = 1'b0;
                end else if (state_q == S_EXT && !exp_s2_q) begin
                    state_d = S_ACK;
                    dtack_d = 1'b0;
                end else if (tcnt_q == TMO_LAST) begin
                    state_d = S_FAULT;
                    berr_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (state_q == S_WAIT) wcnt_d = wcnt_q - 8'd1;
                end
            end
            S_ACK, S_FAULT: begin
                if (AS) begin
                    // Only DTACK-terminated cycles advance the boot overlay count.
                    if (!dtack_q && boot_q) begin
                        bcnt_d = bcnt_q + 8'd1;
                        if (bcnt_q == BOOT_LAST) boot_d = 1'b0;
                    end
                    dtack_d = 1'b1;
                    vpa_d   = 1'b1;
                    berr_d  = 1'b1;
                    cend_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 8'd0;
            tcnt_q   <= 8'd0;
            bcnt_q   <= 8'd0;
            iack_q   <= 1'b0;
            boot_q   <= 1'b1;
            dtack_q  <= 1'b1;
            vpa_q    <= 1'b1;
            berr_q   <= 1'b1;
            cend_q   <= 1'b0;
            exp_s1_q <= 1'b1;
            exp_s2_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            tcnt_q   <= tcnt_d;
            bcnt_q   <= bcnt_d;
            iack_q   <= iack_d;
            boot_q   <= boot_d;
            dtack_q  <= dtack_d;
            vpa_q    <= vpa_d;
            berr_q   <= berr_d;
            cend_q   <= cend_d;
            exp_s1_q <= exp_s1_d;
            exp_s2_q <= exp_s2_d;
        end
    end

    assign DTACK     = dtack_q;
    assign VPA       = vpa_q;
    assign BERR      = berr_q;
    assign BOOT      = boot_q;
    assign CYCLE_END = cend_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller: vector table plus hand-written multi-cycle sequences.
module tb_bus_cycle_controller;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       AS = 1'b1;
    logic       RW = 1'b1;
    logic [2:0] FC = 3'd0;
    logic       ROM_SEL = 1'b0;
    logic       RAM_SEL = 1'b0;
    logic       IO_SEL = 1'b0;
    logic       EXP_SEL = 1'b0;
    logic       EXP_DTACK = 1'b1;
    logic       DTACK, VPA, BERR, BOOT, CYCLE_END;

    int passed = 0;
    int total  = 0;
    int bcnt_m = 0;
    logic eb = 1'b1;

    bus_cycle_controller dut (
        .CLK(CLK), .RST(RST), .AS(AS), .RW(RW), .FC(FC),
        .ROM_SEL(ROM_SEL), .RAM_SEL(RAM_SEL), .IO_SEL(IO_SEL), .EXP_SEL(EXP_SEL),
        .EXP_DTACK(EXP_DTACK),
        .DTACK(DTACK), .VPA(VPA), .BERR(BERR), .BOOT(BOOT), .CYCLE_END(CYCLE_END)
    );

    always #5 CLK = ~CLK;

    // outputs packed as {DTACK,VPA,BERR,BOOT,CYCLE_END}
    typedef struct {
        logic       rst;
        logic       as_n;
        logic [2:0] fc;
        logic       rom, ram, io, exps;
        logic [4:0] exp_out;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [4:0] outs();
        return {DTACK, VPA, BERR, BOOT, CYCLE_END};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b (DTACK,VPA,BERR,BOOT,CYCLE_END)", name, act, exp);
        else
            passed++;
    endtask

    task automatic idle_inputs();
        AS = 1'b1; FC = 3'd0; ROM_SEL = 1'b0; RAM_SEL = 1'b0; IO_SEL = 1'b0; EXP_SEL = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b0;
        tick();
        chk("reset", outs(), 5'b11110);
        RST = 1'b1;
        bcnt_m = 0;
        eb = 1'b1;
    endtask

    task automatic end_cycle(input string name, input logic dtack_term);
        AS = 1'b1;
        tick();
        if (dtack_term && eb) begin
            bcnt_m++;
            if (bcnt_m == 4) eb = 1'b0;
        end
        chk({name, "_end"}, outs(), {4'b1110 | {3'b000, eb}, 1'b1});
        tick();
        chk({name, "_idle"}, outs(), {3'b111, eb, 1'b0});
    endtask

    task automatic rom_cycle(input string name);
        logic [4:0] early;
        early = 5'b11111;
        AS = 1'b0; ROM_SEL = 1'b1;
        tick();
        ROM_SEL = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            tick();
            early &= outs() | 5'b00011;
        end
        chk({name, "_nodtack_early"}, early | 5'b00011, 5'b11111);
        tick();
        chk({name, "_dtack_k3"}, outs(), {3'b011, eb, 1'b0});
        end_cycle(name, 1'b1);
    endtask

    initial begin
        logic [4:0] acc;

        // reset, RAM read with mid-cycle select change, IACK, IO abort, ROM-over-RAM priority
        tbl.push_back('{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01110});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10110});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11110});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11110});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01110});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11110});

        #2;
        foreach (tbl[i]) begin
            RST = tbl[i].rst; AS = tbl[i].as_n; FC = tbl[i].fc;
            ROM_SEL = tbl[i].rom; RAM_SEL = tbl[i].ram; IO_SEL = tbl[i].io; EXP_SEL = tbl[i].exps;
            tick();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp_out);
        end

        // boot overlay across ROM cycles with a watchdog cycle in between
        do_reset();
        rom_cycle("rom1");
        rom_cycle("rom2");
        rom_cycle("rom3");

        AS = 1'b0;
        tick();
        acc = 5'b11111;
        for (int j = 1; j <= 63; j++) begin
            tick();
            acc &= outs();
        end
        chk("wdog_no_early", acc, 5'b11110);
        tick();
        chk("wdog_berr_k64", outs(), 5'b11010);
        tick();
        chk("wdog_hold", outs(), 5'b11010);
        end_cycle("wdog", 1'b0);

        rom_cycle("rom4");
        chk("boot_low_after4", {4'b0000, BOOT}, 5'b00000);
        rom_cycle("rom5");

        // expansion slot handshake through the synchronizer
        AS = 1'b0; EXP_SEL = 1'b1;
        tick();
        EXP_SEL = 1'b0;
        acc = 5'b11111;
        for (int j = 1; j <= 10; j++) begin
            tick();
            acc &= outs() | 5'b00011;
        end
        chk("exp_wait", acc, 5'b11111);
        EXP_DTACK = 1'b0;
        tick();
        tick();
        chk("exp_k12", outs(), 5'b11100);
        tick();
        chk("exp_dtack_k13", outs(), 5'b01100);
        EXP_DTACK = 1'b1;
        end_cycle("exp", 1'b1);

        // reset during a wait-state cycle abandons it and restores BOOT
        AS = 1'b0; IO_SEL = 1'b1;
        tick();
        IO_SEL = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        chk("rst_in_wait", outs(), 5'b11110);
        RST = 1'b1; AS = 1'b1;
        tick();
        chk("after_rst", outs(), 5'b11110);
        AS = 1'b0; RAM_SEL = 1'b1;
        tick();
        RAM_SEL = 1'b0;
        tick();
        chk("ram_after_rst", outs(), 5'b01110);
        AS = 1'b1;
        tick();
        chk("ram_after_rst_end", outs(), 5'b11111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
